hast_axil_traffic_gen: RTL and testbench
========================================

HAST_AXIL_TRAFFIC_GEN -- requirements
Module: hast_axil_traffic_gen

Interface
REQ-001 SHALL have parameter C_M_TARGET_SLAVE_BASE_ADDR, default 32'h4000_0000: first target address.
REQ-002 SHALL have parameter C_M_AXI_ADDR_WIDTH, default 32: address width.
REQ-003 SHALL have parameter C_M_AXI_DATA_WIDTH, default 32: data width; legal values 32, 64.
REQ-004 SHALL have parameter C_M_TRANSACTIONS_NUM, default 4: words per run; legal range 1..256.
REQ-005 SHALL have parameter C_PATTERN_MODE, default 0: 0 = incrementing pattern, 1 = LFSR pattern.
REQ-006 SHALL have parameter C_PATTERN_SEED, default 32'h0101FFFF: pattern seed, zero-extended to the data width.
REQ-007 SHALL have port M_AXI_ACLK, input, 1 bit: the single clock.
REQ-008 SHALL have port M_AXI_ARESETN, input, 1 bit: reset; synchronous, active-low.
REQ-009 SHALL have port INIT_AXI_TXN, input, 1 bit: a rising edge starts a run.
REQ-010 SHALL have port TXN_DONE, output, 1 bit: run complete; held until the next start.
REQ-011 SHALL have port ERROR, output, 1 bit: sticky failure flag for the current run.
REQ-012 SHALL have AW channel ports: M_AXI_AWADDR out ADDR_W; M_AXI_AWPROT out 3; M_AXI_AWVALID out 1; M_AXI_AWREADY in 1.
REQ-013 SHALL have W channel ports: M_AXI_WDATA out DATA_W; M_AXI_WSTRB out DATA_W/8; M_AXI_WVALID out 1; M_AXI_WREADY in 1.
REQ-014 SHALL have B channel ports: M_AXI_BRESP in 2; M_AXI_BVALID in 1; M_AXI_BREADY out 1.
REQ-015 SHALL have AR channel ports: M_AXI_ARADDR out ADDR_W; M_AXI_ARPROT out 3; M_AXI_ARVALID out 1; M_AXI_ARREADY in 1.
REQ-016 SHALL have R channel ports: M_AXI_RDATA in DATA_W; M_AXI_RRESP in 2; M_AXI_RVALID in 1; M_AXI_RREADY out 1.

Function
REQ-017 SHALL implement a state machine with states IDLE, WRITE, READ and DONE.
REQ-018 SHALL detect an INIT_AXI_TXN rising edge with a registered copy of the input; in IDLE or DONE the edge clears TXN_DONE and ERROR, resets the index and pattern, and enters WRITE on the next cycle.
REQ-019 SHALL ignore an INIT_AXI_TXN rising edge while in WRITE or READ.
REQ-020 In WRITE, word i SHALL use address BASE + i*(DATA_W/8), AWPROT 3'b000, WSTRB all ones, and WDATA equal to pattern word i.
REQ-021 SHALL assert AWVALID and WVALID in the same cycle and deassert each independently on its own ready; a ready that is already high in the first valid cycle completes that channel in one cycle.
REQ-022 SHALL assert BREADY only after both AW and W have completed, and SHALL allow one outstanding write at most.
REQ-023 SHALL issue the next write in the cycle after the B handshake.
REQ-024 SHALL transition WRITE->READ after the B handshake of word N-1, restarting the index and pattern from the seed.
REQ-025 In READ, SHALL assert ARVALID until ARREADY, then assert RREADY until RVALID; one outstanding read at most.
REQ-026 SHALL compare RDATA with regenerated pattern word i in the R handshake cycle.
REQ-027 SHALL set ERROR on any data mismatch, BRESP != 2'b00, or RRESP != 2'b00, and the run SHALL still complete all N reads.
REQ-028 SHALL transition READ->DONE after the R handshake of word N-1, with TXN_DONE=1 from the following cycle.
REQ-029 Incrementing pattern: word i = seed + i, modulo 2^DATA_W.
REQ-030 LFSR pattern: word 0 = seed, word i+1 = Galois step of word i; a zero seed SHALL be replaced by 1.
REQ-031 Address arithmetic SHALL wrap modulo 2^ADDR_W.

Reset
REQ-032 While M_AXI_ARESETN=0 at a clock edge, all VALID/READY outputs, TXN_DONE and ERROR SHALL be 0, addresses and WDATA SHALL be 0, and the state SHALL be IDLE.
REQ-033 Reset mid-run SHALL abandon the run with no pending handshakes; the edge-detect register SHALL reset to 1, so an INIT already high at release does not start a run.

Configuration
REQ-034 With HAST_TG_FAILINFO_EN defined, SHALL add outputs FAIL_ADDR (ADDR_W), FAIL_DATA (DATA_W) and FAIL_CNT (9 bits).
REQ-035 FAIL_ADDR and FAIL_DATA SHALL capture the address and RDATA of the first data mismatch in the run.
REQ-036 FAIL_CNT SHALL count data mismatches, saturating at 511, and all three outputs SHALL be cleared at reset and at each start.
REQ-037 Without HAST_TG_FAILINFO_EN, these ports and their logic SHALL be absent.

Structure
REQ-038 Package hast_tg_pkg SHALL hold the state enum, the RESP_OKAY constant, the LFSR polynomials (32: 32'h8020_0003; 64: 64'hD800_0000_0000_0000), and a pattern-mode enum.
REQ-039 Sub-module hast_tg_pattern (parameters width and mode; inputs load and step; output word) SHALL generate the pattern and be instantiated once, reloaded between phases.

Verification
REQ-040 Defaults, zero-wait slave: INIT pulse -> writes 0x0101FFFF..0x01020002 to 0x40000000..0x4000000C, reads match, TXN_DONE=1, ERROR=0.
REQ-041 AWREADY delayed 3 cycles after WREADY on every write: the W channel completes first, BREADY waits for AW, and the run passes.
REQ-042 Slave corrupts read word 2 to 0xDEAD0011: ERROR=1, all 4 reads still issued, TXN_DONE=1; with FAILINFO_EN, FAIL_ADDR=0x40000008, FAIL_CNT=1.
REQ-043 BRESP=2'b10 on write 1: ERROR=1 and the run completes; a second INIT with an OKAY slave clears ERROR and the run passes.
REQ-044 DATA_W=64, MODE=1, N=16, seed 0: the first word is 1, addresses step by 8, and all readbacks match.
REQ-045 Reset asserted mid-READ: next cycle all valids are 0 and TXN_DONE=0; INIT held high across release produces no run until it toggles.

Source files
------------

// File: rtl/hast_tg_pkg.sv
// rtl/hast_tg_pkg.sv - shared types and constants for the AXI-Lite traffic generator
package hast_tg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    typedef enum logic {
        PAT_INCR = 1'b0,
        PAT_LFSR = 1'b1
    } pattern_mode_e;

    localparam logic [1:0]  RESP_OKAY    = 2'b00;
    localparam logic [31:0] LFSR_POLY_32 = 32'h8020_0003;
    localparam logic [63:0] LFSR_POLY_64 = 64'hD800_0000_0000_0000;

    function automatic logic [63:0] lfsr_poly(input int width);
        return (width == 64) ? LFSR_POLY_64 : {32'h0, LFSR_POLY_32};
    endfunction

endpackage

// File: rtl/hast_axil_traffic_gen_if.sv
// rtl/hast_axil_traffic_gen_if.sv - AXI-Lite bundle between traffic generator and slave
interface hast_axil_traffic_gen_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   awaddr;
    logic [2:0]          awprot;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [ADDR_W-1:0]   araddr;
    logic [2:0]          arprot;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/hast_tg_pattern.sv
// rtl/hast_tg_pattern.sv - incrementing or Galois-LFSR data pattern source
module hast_tg_pattern
    import hast_tg_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int MODE  = 0
) (
    input  logic             clk_i,
    input  logic             resetn_i,
    input  logic             load_i,
    input  logic             step_i,
    input  logic [WIDTH-1:0] seed_i,
    output logic [WIDTH-1:0] word_o
);
    localparam logic [WIDTH-1:0] POLY     = WIDTH'(lfsr_poly(WIDTH));
    localparam bit               IS_LFSR  = (MODE == int'(PAT_LFSR));

    logic [WIDTH-1:0] word_q, word_d, seed_eff, next_word;

    // An all-zero LFSR state would lock up, so a zero seed starts at 1.
    assign seed_eff  = (IS_LFSR && seed_i == '0) ? WIDTH'(1) : seed_i;
    assign next_word = IS_LFSR ? ((word_q >> 1) ^ ({WIDTH{word_q[0]}} & POLY))
                               : word_q + WIDTH'(1);

    always_comb begin
        word_d = word_q;
        if (load_i)      word_d = seed_eff;
        else if (step_i) word_d = next_word;
    end

    always_ff @(posedge clk_i) begin
        if (!resetn_i) word_q <= '0;
        else           word_q <= word_d;
    end

    assign word_o = word_q;
endmodule

// File: rtl/hast_axil_traffic_gen.sv
// rtl/hast_axil_traffic_gen.sv - AXI-Lite write-then-readback traffic generator
// Optional first-failure capture outputs are enabled by HAST_TG_FAILINFO_EN.
module hast_axil_traffic_gen
    import hast_tg_pkg::*;
#(
    parameter logic [31:0] C_M_TARGET_SLAVE_BASE_ADDR = 32'h4000_0000,
    parameter int          C_M_AXI_ADDR_WIDTH         = 32,
    parameter int          C_M_AXI_DATA_WIDTH         = 32,
    parameter int          C_M_TRANSACTIONS_NUM       = 4,
    parameter int          C_PATTERN_MODE             = 0,
    parameter logic [31:0] C_PATTERN_SEED             = 32'h0101_FFFF
) (
    input  logic                              M_AXI_ACLK,
    input  logic                              M_AXI_ARESETN,
    input  logic                              INIT_AXI_TXN,
    output logic                              TXN_DONE,
    output logic                              ERROR,
`ifdef HAST_TG_FAILINFO_EN
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     FAIL_ADDR,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     FAIL_DATA,
    output logic [8:0]                        FAIL_CNT,
`endif
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
    output logic [2:0]                        M_AXI_AWPROT,
    output logic                              M_AXI_AWVALID,
    input  logic                              M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
    output logic                              M_AXI_WVALID,
    input  logic                              M_AXI_WREADY,
    input  logic [1:0]                        M_AXI_BRESP,
    input  logic                              M_AXI_BVALID,
    output logic                              M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
    output logic [2:0]                        M_AXI_ARPROT,
    output logic                              M_AXI_ARVALID,
    input  logic                              M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
    input  logic [1:0]                        M_AXI_RRESP,
    input  logic                              M_AXI_RVALID,
    output logic                              M_AXI_RREADY
);
    localparam int             AW       = C_M_AXI_ADDR_WIDTH;
    localparam int             DW       = C_M_AXI_DATA_WIDTH;
    localparam logic [AW-1:0]  BASE     = AW'(C_M_TARGET_SLAVE_BASE_ADDR);
    localparam logic [AW-1:0]  STEP     = AW'(DW / 8);
    localparam logic [7:0]     LAST_IDX = 8'(C_M_TRANSACTIONS_NUM - 1);

    state_e        state_q, state_d;
    logic          init_q;
    logic [7:0]    idx_q, idx_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
    logic          arvalid_q, arvalid_d, rready_q, rready_d;
    logic          done_q, done_d, error_q, error_d;
    logic          pat_load, pat_step, start, last, b_hs, r_hs, data_bad;
    logic [DW-1:0] pat_word;

    hast_tg_pattern #(.WIDTH(DW), .MODE(C_PATTERN_MODE)) u_pattern (
        .clk_i    (M_AXI_ACLK),
        .resetn_i (M_AXI_ARESETN),
        .load_i   (pat_load),
        .step_i   (pat_step),
        .seed_i   (DW'(C_PATTERN_SEED)),
        .word_o   (pat_word)
    );

    assign start    = INIT_AXI_TXN && !init_q && (state_q == ST_IDLE || state_q == ST_DONE);
    assign last     = (idx_q == LAST_IDX);
    assign b_hs     = bready_q && M_AXI_BVALID;
    assign r_hs     = rready_q && M_AXI_RVALID;
    assign data_bad = (M_AXI_RDATA != pat_word);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        addr_d    = addr_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        bready_d  = bready_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        done_d    = done_q;
        error_d   = error_q;
        pat_load  = 1'b0;
        pat_step  = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d   = ST_WRITE;
                    done_d    = 1'b0;
                    error_d   = 1'b0;
                    idx_d     = '0;
                    addr_d    = BASE;
                    pat_load  = 1'b1;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                end
            end
            ST_WRITE: begin
                if (awvalid_q && M_AXI_AWREADY) awvalid_d = 1'b0;
                if (wvalid_q && M_AXI_WREADY)   wvalid_d  = 1'b0;
                // BREADY rises only once both address and data have been accepted.
                if ((awvalid_q || wvalid_q) && (!awvalid_q || M_AXI_AWREADY)
                        && (!wvalid_q || M_AXI_WREADY))
                    bready_d = 1'b1;
                if (b_hs) begin
                    bready_d = 1'b0;
                    if (M_AXI_BRESP != RESP_OKAY) error_d = 1'b1;
                    if (last) begin
                        state_d   = ST_READ;
                        idx_d     = '0;
                        addr_d    = BASE;
                        pat_load  = 1'b1;
                        arvalid_d = 1'b1;
                    end else begin
                        idx_d     = idx_q + 8'd1;
                        addr_d    = addr_q + STEP;
                        pat_step  = 1'b1;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end
                end
            end
            ST_READ: begin
                if (arvalid_q && M_AXI_ARREADY) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                end
                if (r_hs) begin
                    rready_d = 1'b0;
                    if (data_bad || M_AXI_RRESP != RESP_OKAY) error_d = 1'b1;
                    if (last) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        idx_d     = idx_q + 8'd1;
                        addr_d    = addr_q + STEP;
                        pat_step  = 1'b1;
                        arvalid_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge M_AXI_ACLK) begin
        if (!M_AXI_ARESETN) begin
            state_q   <= ST_IDLE;
            init_q    <= 1'b1;
            idx_q     <= '0;
            addr_q    <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            init_q    <= INIT_AXI_TXN;
            idx_q     <= idx_d;
            addr_q    <= addr_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            done_q    <= done_d;
            error_q   <= error_d;
        end
    end

`ifdef HAST_TG_FAILINFO_EN
    logic [AW-1:0] fail_addr_q;
    logic [DW-1:0] fail_data_q;
    logic [8:0]    fail_cnt_q;

    always_ff @(posedge M_AXI_ACLK) begin
        if (!M_AXI_ARESETN || start) begin
            fail_addr_q <= '0;
            fail_data_q <= '0;
            fail_cnt_q  <= '0;
        end else if (state_q == ST_READ && r_hs && data_bad) begin
            if (fail_cnt_q == '0) begin
                fail_addr_q <= addr_q;
                fail_data_q <= M_AXI_RDATA;
            end
            if (fail_cnt_q != 9'h1FF) fail_cnt_q <= fail_cnt_q + 9'd1;
        end
    end

    assign FAIL_ADDR = fail_addr_q;
    assign FAIL_DATA = fail_data_q;
    assign FAIL_CNT  = fail_cnt_q;
`endif

    assign TXN_DONE      = done_q;
    assign ERROR         = error_q;
    assign M_AXI_AWADDR  = addr_q;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_WDATA   = pat_word;
    assign M_AXI_WSTRB   = '1;
    assign M_AXI_WVALID  = wvalid_q;
    assign M_AXI_BREADY  = bready_q;
    assign M_AXI_ARADDR  = addr_q;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_ARVALID = arvalid_q;
    assign M_AXI_RREADY  = rready_q;
endmodule

// File: tb/tb_hast_axil_traffic_gen.sv
// tb/tb_hast_axil_traffic_gen.sv - directed bench for the AXI-Lite traffic generator
module tb_hast_axil_traffic_gen;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic init32 = 1'b0, init64 = 1'b0;
    logic done32, err32, done64, err64;
    int   checks = 0, failures = 0;

    always #5 clk = ~clk;

    hast_axil_traffic_gen_if #(.ADDR_W(32), .DATA_W(32)) axi ();
    hast_axil_traffic_gen_if #(.ADDR_W(32), .DATA_W(64)) axi64 ();

`ifdef HAST_TG_FAILINFO_EN
    logic [31:0] fail_addr;
    logic [31:0] fail_data;
    logic [8:0]  fail_cnt;
    logic [31:0] fail_addr64;
    logic [63:0] fail_data64;
    logic [8:0]  fail_cnt64;
`endif

    hast_axil_traffic_gen dut (
        .M_AXI_ACLK(clk), .M_AXI_ARESETN(resetn), .INIT_AXI_TXN(init32),
        .TXN_DONE(done32), .ERROR(err32),
`ifdef HAST_TG_FAILINFO_EN
        .FAIL_ADDR(fail_addr), .FAIL_DATA(fail_data), .FAIL_CNT(fail_cnt),
`endif
        .M_AXI_AWADDR(axi.awaddr), .M_AXI_AWPROT(axi.awprot), .M_AXI_AWVALID(axi.awvalid),
        .M_AXI_AWREADY(axi.awready), .M_AXI_WDATA(axi.wdata), .M_AXI_WSTRB(axi.wstrb),
        .M_AXI_WVALID(axi.wvalid), .M_AXI_WREADY(axi.wready), .M_AXI_BRESP(axi.bresp),
        .M_AXI_BVALID(axi.bvalid), .M_AXI_BREADY(axi.bready), .M_AXI_ARADDR(axi.araddr),
        .M_AXI_ARPROT(axi.arprot), .M_AXI_ARVALID(axi.arvalid), .M_AXI_ARREADY(axi.arready),
        .M_AXI_RDATA(axi.rdata), .M_AXI_RRESP(axi.rresp), .M_AXI_RVALID(axi.rvalid),
        .M_AXI_RREADY(axi.rready)
    );

    hast_axil_traffic_gen #(
        .C_M_AXI_DATA_WIDTH(64), .C_M_TRANSACTIONS_NUM(16),
        .C_PATTERN_MODE(1), .C_PATTERN_SEED(32'h0)
    ) dut64 (
        .M_AXI_ACLK(clk), .M_AXI_ARESETN(resetn), .INIT_AXI_TXN(init64),
        .TXN_DONE(done64), .ERROR(err64),
`ifdef HAST_TG_FAILINFO_EN
        .FAIL_ADDR(fail_addr64), .FAIL_DATA(fail_data64), .FAIL_CNT(fail_cnt64),
`endif
        .M_AXI_AWADDR(axi64.awaddr), .M_AXI_AWPROT(axi64.awprot), .M_AXI_AWVALID(axi64.awvalid),
        .M_AXI_AWREADY(axi64.awready), .M_AXI_WDATA(axi64.wdata), .M_AXI_WSTRB(axi64.wstrb),
        .M_AXI_WVALID(axi64.wvalid), .M_AXI_WREADY(axi64.wready), .M_AXI_BRESP(axi64.bresp),
        .M_AXI_BVALID(axi64.bvalid), .M_AXI_BREADY(axi64.bready), .M_AXI_ARADDR(axi64.araddr),
        .M_AXI_ARPROT(axi64.arprot), .M_AXI_ARVALID(axi64.arvalid), .M_AXI_ARREADY(axi64.arready),
        .M_AXI_RDATA(axi64.rdata), .M_AXI_RRESP(axi64.rresp), .M_AXI_RVALID(axi64.rvalid),
        .M_AXI_RREADY(axi64.rready)
    );

    // 32-bit slave: programmable AW delay, B error injection, read corruption.
    int aw_delay = 0, aw_wait = 0, corrupt_word = -1, bad_bresp_word = -1;
    int wr_cnt = 0, rd_cnt = 0, w_first = 0, bready_early = 0;
    logic [31:0] mem [16];
    logic [31:0] wr_addr [16];
    logic [31:0] wr_data [16];
    logic [31:0] rd_addr [16];

    always @(negedge clk) begin
        if (!resetn) begin
            axi.awready = 1'b0; axi.bvalid = 1'b0; axi.rvalid = 1'b0; aw_wait = 0;
        end else begin
            if (axi.awvalid) begin
                axi.awready = (aw_wait >= aw_delay);
                aw_wait++;
            end else begin
                aw_wait = 0;
                axi.awready = (aw_delay == 0);
            end
            if (axi.bready && (axi.awvalid || axi.wvalid)) bready_early++;
            if (axi.awvalid && !axi.wvalid) w_first++;
            if (axi.bready && !axi.bvalid) begin
                axi.bvalid = 1'b1;
                axi.bresp  = (wr_cnt == bad_bresp_word) ? 2'b10 : 2'b00;
                mem[axi.awaddr[5:2]] = axi.wdata;
                wr_addr[wr_cnt % 16] = axi.awaddr;
                wr_data[wr_cnt % 16] = axi.wdata;
                wr_cnt++;
            end else if (!axi.bready) axi.bvalid = 1'b0;
            if (axi.rready && !axi.rvalid) begin
                axi.rvalid = 1'b1;
                axi.rdata  = (rd_cnt == corrupt_word) ? 32'hDEAD_0011 : mem[axi.araddr[5:2]];
                rd_addr[rd_cnt % 16] = axi.araddr;
                rd_cnt++;
            end else if (!axi.rready) axi.rvalid = 1'b0;
        end
    end

    // 64-bit slave: always ready, echoes written data.
    int wr64_cnt = 0, rd64_cnt = 0;
    logic [63:0] mem64 [16];
    logic [31:0] wr64_addr [16];
    logic [63:0] wr64_data [16];

    always @(negedge clk) begin
        if (!resetn) begin
            axi64.bvalid = 1'b0; axi64.rvalid = 1'b0;
        end else begin
            if (axi64.bready && !axi64.bvalid) begin
                axi64.bvalid = 1'b1;
                mem64[axi64.awaddr[6:3]] = axi64.wdata;
                wr64_addr[wr64_cnt % 16] = axi64.awaddr;
                wr64_data[wr64_cnt % 16] = axi64.wdata;
                wr64_cnt++;
            end else if (!axi64.bready) axi64.bvalid = 1'b0;
            if (axi64.rready && !axi64.rvalid) begin
                axi64.rvalid = 1'b1;
                axi64.rdata  = mem64[axi64.araddr[6:3]];
                rd64_cnt++;
            end else if (!axi64.rready) axi64.rvalid = 1'b0;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run32(input string tag);
        int n = 0;
        @(negedge clk); init32 = 1'b1;
        @(negedge clk); @(negedge clk);
        check({tag, "_done_cleared"}, done32, 1'b0);
        init32 = 1'b0;
        while (!done32 && n < 1000) begin @(negedge clk); n++; end
        check({tag, "_done"}, done32, 1'b1);
    endtask

    task automatic check_writes32(input string tag);
        check({tag, "_wr_cnt"}, wr_cnt, 4);
        check({tag, "_wr_addr0"}, wr_addr[0], 32'h4000_0000);
        check({tag, "_wr_data0"}, wr_data[0], 32'h0101_FFFF);
        check({tag, "_wr_addr3"}, wr_addr[3], 32'h4000_000C);
        check({tag, "_wr_data1"}, wr_data[1], 32'h0102_0000);
        check({tag, "_wr_data3"}, wr_data[3], 32'h0102_0002);
        check({tag, "_rd_cnt"}, rd_cnt, 4);
        check({tag, "_rd_addr2"}, rd_addr[2], 32'h4000_0008);
    endtask

    initial begin
        int n;
        axi.wready = 1'b1; axi.arready = 1'b1; axi.rresp = 2'b00; axi.bresp = 2'b00;
        axi.rdata = '0;
        axi64.awready = 1'b1; axi64.wready = 1'b1; axi64.arready = 1'b1;
        axi64.bresp = 2'b00; axi64.rresp = 2'b00; axi64.rdata = '0;

        repeat (3) @(negedge clk);
        check("rst_awvalid", axi.awvalid, 1'b0);
        check("rst_wvalid", axi.wvalid, 1'b0);
        check("rst_bready", axi.bready, 1'b0);
        check("rst_arvalid", axi.arvalid, 1'b0);
        check("rst_rready", axi.rready, 1'b0);
        check("rst_done", done32, 1'b0);
        check("rst_error", err32, 1'b0);
        check("rst_awaddr", axi.awaddr, 32'h0);
        check("rst_wdata", axi.wdata, 32'h0);
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        // Zero-wait slave
        run32("basic");
        check("basic_error", err32, 1'b0);
        check("basic_wstrb", axi.wstrb, 4'hF);
        check_writes32("basic");

        // AW accepted three cycles after W on every write
        wr_cnt = 0; rd_cnt = 0; w_first = 0; aw_delay = 3;
        run32("awdly");
        check("awdly_error", err32, 1'b0);
        check("awdly_w_first_cycles", w_first, 12);
        check_writes32("awdly");
        aw_delay = 0;

        // Read word 2 corrupted
        wr_cnt = 0; rd_cnt = 0; corrupt_word = 2;
        run32("corrupt");
        check("corrupt_error", err32, 1'b1);
        check("corrupt_rd_cnt", rd_cnt, 4);
`ifdef HAST_TG_FAILINFO_EN
        check("corrupt_fail_addr", fail_addr, 32'h4000_0008);
        check("corrupt_fail_data", fail_data, 32'hDEAD_0011);
        check("corrupt_fail_cnt", fail_cnt, 9'd1);
`endif
        corrupt_word = -1;

        // SLVERR on write 1, then a clean rerun clears ERROR
        wr_cnt = 0; rd_cnt = 0; bad_bresp_word = 1;
        run32("bresp");
        check("bresp_error", err32, 1'b1);
        check("bresp_rd_cnt", rd_cnt, 4);
        bad_bresp_word = -1;
        wr_cnt = 0; rd_cnt = 0;
        run32("rerun");
        check("rerun_error", err32, 1'b0);
`ifdef HAST_TG_FAILINFO_EN
        check("rerun_fail_cnt", fail_cnt, 9'd0);
`endif

        // 64-bit LFSR, zero seed, 16 words
        @(negedge clk); init64 = 1'b1;
        @(negedge clk); init64 = 1'b0;
        n = 0;
        while (!done64 && n < 2000) begin @(negedge clk); n++; end
        check("lfsr_done", done64, 1'b1);
        check("lfsr_error", err64, 1'b0);
        check("lfsr_wr_cnt", wr64_cnt, 16);
        check("lfsr_rd_cnt", rd64_cnt, 16);
        check("lfsr_word0", wr64_data[0], 64'h1);
        check("lfsr_word1", wr64_data[1], 64'hD800_0000_0000_0000);
        check("lfsr_word2", wr64_data[2], 64'h6C00_0000_0000_0000);
        check("lfsr_addr1", wr64_addr[1], 32'h4000_0008);
        check("lfsr_addr15", wr64_addr[15], 32'h4000_0078);

        // Reset during READ, INIT held high across release
        wr_cnt = 0; rd_cnt = 0;
        @(negedge clk); init32 = 1'b1;
        @(negedge clk); init32 = 1'b0;
        n = 0;
        while (!(axi.arvalid || axi.rready) && n < 200) begin @(negedge clk); n++; end
        check("midrst_reached_read", axi.arvalid | axi.rready, 1'b1);
        resetn = 1'b0; init32 = 1'b1;
        @(negedge clk);
        check("midrst_awvalid", axi.awvalid, 1'b0);
        check("midrst_wvalid", axi.wvalid, 1'b0);
        check("midrst_arvalid", axi.arvalid, 1'b0);
        check("midrst_rready", axi.rready, 1'b0);
        check("midrst_bready", axi.bready, 1'b0);
        check("midrst_done", done32, 1'b0);
        @(negedge clk); resetn = 1'b1;
        wr_cnt = 0; rd_cnt = 0;
        repeat (20) @(negedge clk);
        check("held_init_awvalid", axi.awvalid, 1'b0);
        check("held_init_wr_cnt", wr_cnt, 0);
        check("held_init_done", done32, 1'b0);
        init32 = 1'b0;
        run32("after_rst");
        check("after_rst_error", err32, 1'b0);
        check("after_rst_wr_cnt", wr_cnt, 4);

        check("bready_before_aw_w", bready_early, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
